// File: rtl/dmem_lsu.sv
// Load/store initiator for the 64kB data memory: word-only memory port, sub-word RMW stores, fault flagging.
// Optional LSU_ERR_CAPTURE_EN adds a sticky first-fault address capture (ERR_CLR/ERR_STICKY/ERR_ADDR).
module dmem_lsu #(
  parameter int          ADDR_DEPTH = 14,
  parameter logic [31:0] WIN_BASE   = 32'h0001_8000,
  parameter logic [31:0] WIN_SIZE   = 32'h0001_0000
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  REQ_VALID,
  output logic                  REQ_READY,
  input  logic                  REQ_WE,
  input  logic [1:0]            REQ_SIZE,
  input  logic                  REQ_UNSIGNED,
  input  logic [31:0]           REQ_ADDR,
  input  logic [31:0]           REQ_WDATA,
  output logic                  RSP_VALID,
  output logic [31:0]           RSP_RDATA,
  output logic                  RSP_ERR,
  output logic                  MEM_RDEN,
  output logic                  MEM_WEN,
  output logic [1:0]            MEM_BYTE_SEL,
  output logic                  MEM_SIGN,
  output logic [ADDR_DEPTH-1:0] MEM_ADDR,
  output logic [31:0]           MEM_DATA_IN,
  input  logic [31:0]           MEM_DATA_OUT
`ifdef LSU_ERR_CAPTURE_EN
  ,
  input  logic                  ERR_CLR,
  output logic                  ERR_STICKY,
  output logic [31:0]           ERR_ADDR
`endif
);

  typedef enum logic [1:0] {IDLE, RD, CAP, WR} state_t;

  state_t                state, state_n;
  logic                  we_q, uns_q;
  logic [1:0]            size_q;
  logic [ADDR_DEPTH+1:0] addr_q;
  logic [31:0]           merge_q;  // store data at accept, merged write word after CAP
  logic                  rsp_valid_q, rsp_err_q;
  logic [31:0]           rsp_rdata_q;

  logic        accept, misaligned, out_of_win, fault;
  logic [31:0] shifted, ld_val, merged;

  assign accept     = REQ_VALID && REQ_READY;
  assign misaligned = (REQ_SIZE == 2'b01 && REQ_ADDR[0]) || (REQ_SIZE[1] && REQ_ADDR[1:0] != 2'b00);
  // 33-bit compare so the window end never wraps
  assign out_of_win = ({1'b0, REQ_ADDR} < {1'b0, WIN_BASE}) ||
                      ({1'b0, REQ_ADDR} >= ({1'b0, WIN_BASE} + {1'b0, WIN_SIZE}));
  assign fault      = misaligned || out_of_win;

  always_ff @(posedge CLK) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (accept && !fault) state_n = (REQ_WE && REQ_SIZE[1]) ? WR : RD;
      RD:   state_n = CAP;
      CAP:  state_n = we_q ? WR : IDLE;
      WR:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    shifted = MEM_DATA_OUT >> {addr_q[1:0], 3'b000};
    case (size_q)
      2'b00:   ld_val = uns_q ? {24'h0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   ld_val = uns_q ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: ld_val = shifted;
    endcase
  end

  always_comb begin
    merged = MEM_DATA_OUT;
    if (size_q == 2'b00) merged[{addr_q[1:0], 3'b000} +: 8]  = merge_q[7:0];
    else                 merged[{addr_q[1], 4'b0000} +: 16] = merge_q[15:0];
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      we_q        <= 1'b0;
      uns_q       <= 1'b0;
      size_q      <= 2'b00;
      addr_q      <= '0;
      merge_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      if (accept) begin
        we_q    <= REQ_WE;
        uns_q   <= REQ_UNSIGNED;
        size_q  <= REQ_SIZE;
        addr_q  <= REQ_ADDR[ADDR_DEPTH+1:0];
        merge_q <= REQ_WDATA;
        if (fault) begin
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= 1'b1;
        end
      end
      if (state == CAP) begin
        if (we_q) merge_q <= merged;
        else begin
          rsp_valid_q <= 1'b1;
          rsp_rdata_q <= ld_val;
        end
      end
      if (state == WR) rsp_valid_q <= 1'b1;
    end
  end

`ifdef LSU_ERR_CAPTURE_EN
  logic        err_sticky_q;
  logic [31:0] err_addr_q;

  // a fault arriving alongside ERR_CLR re-captures instead of clearing
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      err_sticky_q <= 1'b0;
      err_addr_q   <= '0;
    end else if (accept && fault && (!err_sticky_q || ERR_CLR)) begin
      err_sticky_q <= 1'b1;
      err_addr_q   <= REQ_ADDR;
    end else if (ERR_CLR) begin
      err_sticky_q <= 1'b0;
      err_addr_q   <= '0;
    end
  end

  assign ERR_STICKY = err_sticky_q;
  assign ERR_ADDR   = err_addr_q;
`else
  // faults are reported through RSP_ERR only
`endif

  assign REQ_READY    = RST_N && (state == IDLE);
  assign MEM_RDEN     = RST_N && (state == RD);
  assign MEM_WEN      = RST_N && (state == WR);
  assign MEM_BYTE_SEL = 2'b10;
  assign MEM_SIGN     = 1'b0;
  assign MEM_ADDR     = addr_q[ADDR_DEPTH+1:2];
  assign MEM_DATA_IN  = MEM_WEN ? merge_q : 32'h0;
  assign RSP_VALID    = rsp_valid_q;
  assign RSP_ERR      = rsp_err_q;
  assign RSP_RDATA    = rsp_rdata_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: word-array memory model on the memory port, byte-level reference model for checking.
module tb_dmem_lsu;
  localparam int          AD    = 14;
  localparam int          WORDS = 1 << AD;
  localparam logic [31:0] BASE  = 32'h0001_8000;
  localparam logic [31:0] SIZE  = 32'h0001_0000;

  logic          CLK = 1'b0;
  logic          RST_N;
  logic          REQ_VALID, REQ_READY, REQ_WE, REQ_UNSIGNED;
  logic [1:0]    REQ_SIZE;
  logic [31:0]   REQ_ADDR, REQ_WDATA;
  logic          RSP_VALID, RSP_ERR;
  logic [31:0]   RSP_RDATA;
  logic          MEM_RDEN, MEM_WEN, MEM_SIGN;
  logic [1:0]    MEM_BYTE_SEL;
  logic [AD-1:0] MEM_ADDR;
  logic [31:0]   MEM_DATA_IN, MEM_DATA_OUT;
`ifdef LSU_ERR_CAPTURE_EN
  logic          ERR_CLR, ERR_STICKY;
  logic [31:0]   ERR_ADDR;
`endif

  int checks = 0;
  int errors = 0;

  dmem_lsu #(.ADDR_DEPTH(AD), .WIN_BASE(BASE), .WIN_SIZE(SIZE)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WE(REQ_WE), .REQ_SIZE(REQ_SIZE),
    .REQ_UNSIGNED(REQ_UNSIGNED), .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
    .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR),
    .MEM_RDEN(MEM_RDEN), .MEM_WEN(MEM_WEN), .MEM_BYTE_SEL(MEM_BYTE_SEL), .MEM_SIGN(MEM_SIGN),
    .MEM_ADDR(MEM_ADDR), .MEM_DATA_IN(MEM_DATA_IN), .MEM_DATA_OUT(MEM_DATA_OUT)
`ifdef LSU_ERR_CAPTURE_EN
    , .ERR_CLR(ERR_CLR), .ERR_STICKY(ERR_STICKY), .ERR_ADDR(ERR_ADDR)
`endif
  );

  always #5 CLK = ~CLK;

  // memory model: synchronous read, data one cycle after RDEN
  logic [31:0] mem [WORDS];
  logic        mem_load = 1'b0;
  always @(posedge CLK) begin
    if (mem_load) begin
      for (int i = 0; i < WORDS; i++) mem[i] <= 32'(i) * 32'h9E37_79B1;
    end else begin
      if (MEM_WEN)  mem[MEM_ADDR] <= MEM_DATA_IN;
      if (MEM_RDEN) MEM_DATA_OUT  <= mem[MEM_ADDR];
    end
  end

  logic [31:0] ref_mem [WORDS];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // reference: computes response, latency, access counts and written word from byte arithmetic
  task automatic ref_model(input logic we, input logic [1:0] sz, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wd,
                           output logic err, output logic [31:0] rd, output int lat,
                           output int n_rd, output int n_wr, output logic [31:0] wword);
    int nb, off, idx;
    logic [31:0] mask, v, w;
    nb   = (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
    off  = int'(addr % 4);
    idx  = int'((addr / 4) % WORDS);
    mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nb)) - 1);
    err  = (off % nb != 0) ||
           (longint'(addr) < longint'(BASE)) || (longint'(addr) >= longint'(BASE) + longint'(SIZE));
    rd = 0; wword = 0; n_rd = 0; n_wr = 0;
    if (err) lat = 1;
    else if (!we) begin
      v = (ref_mem[idx] >> (8 * off)) & mask;
      if (!uns && nb < 4 && v >= (mask / 2 + 1)) v = v | ~mask;
      rd = v; lat = 3; n_rd = 1;
    end else begin
      w = (ref_mem[idx] & ~(mask << (8 * off))) | ((wd & mask) << (8 * off));
      ref_mem[idx] = w;
      wword = w; n_wr = 1;
      lat   = (nb == 4) ? 2 : 4;
      n_rd  = (nb == 4) ? 0 : 1;
    end
  endtask

  // entered #1 after a rising edge; returns #1 after the edge that produced RSP_VALID
  task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd, input string tag,
                        output logic [31:0] got);
    logic e_err; logic [31:0] e_rd, e_ww; int e_lat, e_nrd, e_nwr;
    int lat, n_rd, n_wr;
    ref_model(we, sz, uns, addr, wd, e_err, e_rd, e_lat, e_nrd, e_nwr, e_ww);
    REQ_VALID = 1'b1; REQ_WE = we; REQ_SIZE = sz; REQ_UNSIGNED = uns;
    REQ_ADDR = addr; REQ_WDATA = wd;
    chk({tag, " ready"}, 32'(REQ_READY), 32'd1);
    @(posedge CLK); #1;
    REQ_VALID = 1'b0;
    lat = 0; n_rd = 0; n_wr = 0;
    for (int n = 1; n <= 8; n++) begin
      if (MEM_RDEN) n_rd++;
      if (MEM_WEN) begin
        n_wr++;
        chk({tag, " wdata"}, MEM_DATA_IN, e_ww);
      end
      if (RSP_VALID) begin
        lat = n;
        break;
      end
      @(posedge CLK); #1;
    end
    chk({tag, " latency"}, 32'(lat), 32'(e_lat));
    chk({tag, " err"}, 32'(RSP_ERR), 32'(e_err));
    chk({tag, " rdata"}, RSP_RDATA, e_rd);
    chk({tag, " rden_cycles"}, 32'(n_rd), 32'(e_nrd));
    chk({tag, " wen_cycles"}, 32'(n_wr), 32'(e_nwr));
    got = RSP_RDATA;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got, a;
    int wen_seen, rsp_seen;
    RST_N = 1'b0; REQ_VALID = 1'b1; REQ_WE = 1'b0; REQ_SIZE = 2'b10; REQ_UNSIGNED = 1'b0;
    REQ_ADDR = BASE; REQ_WDATA = 32'h0;
`ifdef LSU_ERR_CAPTURE_EN
    ERR_CLR = 1'b0;
`endif
    for (int i = 0; i < WORDS; i++) ref_mem[i] = 32'(i) * 32'h9E37_79B1;
    mem_load = 1'b1;
    @(posedge CLK); #1;
    mem_load = 1'b0;
    @(posedge CLK); #1;
    chk("rst ready", 32'(REQ_READY), 32'd0);
    chk("rst rden", 32'(MEM_RDEN), 32'd0);
    chk("rst wen", 32'(MEM_WEN), 32'd0);
    chk("rst rsp_valid", 32'(RSP_VALID), 32'd0);
    chk("rst rsp_rdata", RSP_RDATA, 32'd0);
    chk("rst rsp_err", 32'(RSP_ERR), 32'd0);
    chk("tie byte_sel", 32'(MEM_BYTE_SEL), 32'd2);
    chk("tie sign", 32'(MEM_SIGN), 32'd0);
`ifdef LSU_ERR_CAPTURE_EN
    chk("rst err_sticky", 32'(ERR_STICKY), 32'd0);
    chk("rst err_addr", ERR_ADDR, 32'd0);
`endif
    REQ_VALID = 1'b0; RST_N = 1'b1;
    #1 chk("release ready", 32'(REQ_READY), 32'd1);

    do_req(1'b1, 2'b10, 1'b0, 32'h0001_8004, 32'hDEAD_BEEF, "sw", got);
    do_req(1'b0, 2'b10, 1'b0, 32'h0001_8004, 32'h0, "lw", got);
    chk("lw value", got, 32'hDEAD_BEEF);
    do_req(1'b1, 2'b00, 1'b0, 32'h0001_8006, 32'h0000_00A5, "sb", got);
    do_req(1'b0, 2'b10, 1'b0, 32'h0001_8004, 32'h0, "lw after sb", got);
    chk("sb word", got, 32'hDEA5_BEEF);
    do_req(1'b0, 2'b00, 1'b0, 32'h0001_8006, 32'h0, "lb", got);
    chk("lb value", got, 32'hFFFF_FFA5);
    do_req(1'b0, 2'b00, 1'b1, 32'h0001_8006, 32'h0, "lbu", got);
    chk("lbu value", got, 32'h0000_00A5);
    do_req(1'b1, 2'b01, 1'b0, 32'h0001_8006, 32'h0000_1234, "sh", got);
    do_req(1'b0, 2'b01, 1'b0, 32'h0001_8004, 32'h0, "lh", got);
    chk("lh value", got, 32'hFFFF_BEEF);
    do_req(1'b0, 2'b01, 1'b1, 32'h0001_8006, 32'h0, "lhu", got);
    chk("lhu value", got, 32'h0000_1234);
    @(posedge CLK); #1;
    chk("rsp pulse drop", 32'(RSP_VALID), 32'd0);

`ifdef LSU_ERR_CAPTURE_EN
    ERR_CLR = 1'b1;
    @(posedge CLK); #1;
    ERR_CLR = 1'b0;
    chk("clr err_sticky", 32'(ERR_STICKY), 32'd0);
`endif
    do_req(1'b0, 2'b10, 1'b0, 32'h0001_8002, 32'h0, "lw misaligned", got);
    do_req(1'b1, 2'b10, 1'b0, 32'h0002_8000, 32'h1111_1111, "sw out of window", got);
`ifdef LSU_ERR_CAPTURE_EN
    chk("cap err_sticky", 32'(ERR_STICKY), 32'd1);
    chk("cap err_addr", ERR_ADDR, 32'h0001_8002);
`endif

    // window edges and odd alignments
    do_req(1'b0, 2'b10, 1'b0, BASE, 32'h0, "lw base", got);
    do_req(1'b0, 2'b00, 1'b0, BASE - 1, 32'h0, "lb below base", got);
    do_req(1'b1, 2'b10, 1'b0, BASE + SIZE - 4, 32'hCAFE_F00D, "sw last word", got);
    do_req(1'b0, 2'b00, 1'b1, BASE + SIZE - 1, 32'h0, "lbu last byte", got);
    do_req(1'b0, 2'b00, 1'b0, BASE + SIZE, 32'h0, "lb window end", got);
    do_req(1'b1, 2'b01, 1'b0, 32'h0001_8005, 32'h5555, "sh odd", got);
    do_req(1'b0, 2'b11, 1'b0, 32'hFFFF_FFFC, 32'h0, "lw top", got);

    // abandon a byte store by resetting during CAP
    REQ_VALID = 1'b1; REQ_WE = 1'b1; REQ_SIZE = 2'b00; REQ_UNSIGNED = 1'b0;
    REQ_ADDR = 32'h0001_8008; REQ_WDATA = 32'h0000_0077;
    @(posedge CLK); #1;
    REQ_VALID = 1'b0;
    chk("abort rd phase", 32'(MEM_RDEN), 32'd1);
    @(posedge CLK); #1;
    RST_N = 1'b0;
    wen_seen = 0; rsp_seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (MEM_WEN) wen_seen++;
      if (RSP_VALID) rsp_seen++;
      if (i == 2) RST_N = 1'b1;
      @(posedge CLK); #1;
    end
    chk("abort wen", 32'(wen_seen), 32'd0);
    chk("abort rsp", 32'(rsp_seen), 32'd0);
    do_req(1'b0, 2'b10, 1'b0, 32'h0001_8008, 32'h0, "abort word kept", got);

    // randomized mix over a small hot region plus occasional edge addresses
    for (int i = 0; i < 60; i++) begin
      logic [1:0] sz;
      sz = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 9))
        0:       a = BASE - 32'($urandom_range(1, 4));
        1:       a = BASE + SIZE - 32'($urandom_range(0, 4));
        2:       a = $urandom;
        default: a = BASE + 32'($urandom_range(0, 47));
      endcase
      do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, "rand", got);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
